// File: rtl/pl_reset_sequencer.sv
// Releases NUM_STAGES downstream reset domains in ascending order, STAGE_DELAY cycles apart,
// and replays the sequence after an accepted software soft-reset request.
module pl_reset_sequencer #(
  parameter int NUM_STAGES      = 4,
  parameter int STAGE_DELAY     = 16,
  parameter int SOFT_RST_CYCLES = 32
) (
  input  logic                  slowest_sync_clk,
  input  logic                  peripheral_reset,
  input  logic                  soft_reset_req,
  output logic [NUM_STAGES-1:0] stage_aresetn,
  output logic                  seq_done,
  output logic                  seq_busy,
  output logic                  soft_reset_ack
);

  localparam int CNT_MAX = (STAGE_DELAY > SOFT_RST_CYCLES) ? STAGE_DELAY : SOFT_RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_STAGES + 1);

  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST  = CNT_W'(SOFT_RST_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_END    = IDX_W'(NUM_STAGES);

  localparam logic [1:0] ST_HOLD = 2'd0;
  localparam logic [1:0] ST_SEQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_SOFT = 2'd3;

  logic [1:0]            state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [NUM_STAGES-1:0] stage_reg, stage_next;
  logic                  done_reg, done_next;
  logic                  busy_reg, busy_next;
  logic                  ack_reg, ack_next;
  logic                  req_prev_reg;

  logic stage_match;
  logic soft_accept;

  // Only DONE listens for requests; the edge register samples every cycle so a level
  // held high across entry into DONE never looks like a fresh edge.
  assign soft_accept = (state_reg == ST_DONE) && soft_reset_req && !req_prev_reg;
  assign stage_match = (state_reg == ST_SEQ) && (idx_reg != IDX_END) && (cnt_reg == STAGE_LAST);

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      assign stage_next[gi] = soft_accept ? 1'b0
                            : (stage_reg[gi] | (stage_match && (idx_reg == IDX_W'(gi))));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    done_next  = done_reg;
    busy_next  = busy_reg;
    ack_next   = 1'b0;
    case (state_reg)
      ST_HOLD: begin
        state_next = ST_SEQ;
        cnt_next   = '0;
        idx_next   = '0;
        done_next  = 1'b0;
        busy_next  = 1'b1;
      end
      ST_SEQ: begin
        if (idx_reg == IDX_END) begin
          state_next = ST_DONE;
          cnt_next   = '0;
          done_next  = 1'b1;
          busy_next  = 1'b0;
        end else if (cnt_reg == STAGE_LAST) begin
          cnt_next = '0;
          idx_next = idx_reg + IDX_W'(1);
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (soft_accept) begin
          state_next = ST_SOFT;
          cnt_next   = '0;
          done_next  = 1'b0;
          busy_next  = 1'b1;
          ack_next   = 1'b1;
        end
      end
      ST_SOFT: begin
        if (cnt_reg == SOFT_LAST) begin
          state_next = ST_SEQ;
          cnt_next   = '0;
          idx_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_HOLD;
        cnt_next   = '0;
        idx_next   = '0;
        done_next  = 1'b0;
        busy_next  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge slowest_sync_clk or posedge peripheral_reset) begin
    if (peripheral_reset) begin
      state_reg    <= ST_HOLD;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      stage_reg    <= '0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b1;
      ack_reg      <= 1'b0;
      req_prev_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      stage_reg    <= stage_next;
      done_reg     <= done_next;
      busy_reg     <= busy_next;
      ack_reg      <= ack_next;
      req_prev_reg <= soft_reset_req;
    end
  end

  assign stage_aresetn  = stage_reg;
  assign seq_done       = done_reg;
  assign seq_busy       = busy_reg;
  assign soft_reset_ack = ack_reg;

endmodule

// File: tb/tb_pl_reset_sequencer.sv
// Directed bench for pl_reset_sequencer: a default instance and a 1-stage/1-cycle corner instance,
// with expected output snapshots queued per edge and compared on the following falling edge.
module tb_pl_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, req_a, req_b;
  logic [3:0] stage_a;
  logic [0:0] stage_b;
  logic       done_a, busy_a, ack_a, done_b, busy_b, ack_b;

  int compared   = 0;
  int mismatched = 0;
  int edge_cnt   = 0;

  typedef struct {
    int         dut;
    int         at;
    logic [6:0] exp;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  pl_reset_sequencer #(.NUM_STAGES(4), .STAGE_DELAY(16), .SOFT_RST_CYCLES(32)) dut_a (
    .slowest_sync_clk(clk),
    .peripheral_reset(rst_a),
    .soft_reset_req  (req_a),
    .stage_aresetn   (stage_a),
    .seq_done        (done_a),
    .seq_busy        (busy_a),
    .soft_reset_ack  (ack_a)
  );

  pl_reset_sequencer #(.NUM_STAGES(1), .STAGE_DELAY(1), .SOFT_RST_CYCLES(1)) dut_b (
    .slowest_sync_clk(clk),
    .peripheral_reset(rst_b),
    .soft_reset_req  (req_b),
    .stage_aresetn   (stage_b),
    .seq_done        (done_b),
    .seq_busy        (busy_b),
    .soft_reset_ack  (ack_b)
  );

  // Snapshot layout: {stage_aresetn[3:0], seq_done, seq_busy, soft_reset_ack}
  function automatic logic [6:0] obs(input int dut);
    if (dut == 0) return {stage_a, done_a, busy_a, ack_a};
    else          return {3'b000, stage_b, done_b, busy_b, ack_b};
  endfunction

  task automatic cmp(input string tag, input logic [6:0] observed, input logic [6:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b (edge %0d)", tag, observed, expected, edge_cnt);
    end
  endtask

  task automatic push(input int dut, input int at, input logic [3:0] st,
                      input logic d, input logic b, input logic a, input string tag);
    exp_t e;
    e.dut = dut;
    e.at  = at;
    e.exp = {st, d, b, a};
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Waits are bounded by the target edge number, never by a DUT event.
  task automatic goto_edge(input int t);
    while (edge_cnt < t) @(negedge clk);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      goto_edge(e.at);
      cmp(e.tag, obs(e.dut), e.exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, e, x;
    rst_a = 1'b1; rst_b = 1'b1; req_a = 1'b0; req_b = 1'b0;
    repeat (2) @(negedge clk);
    cmp("rst_a", obs(0), 7'b0000_010);
    cmp("rst_b", obs(1), 7'b0000_010);
    repeat (8) @(negedge clk);

    // Power-on sequence with an ignored request pulse at N+20
    rst_a = 1'b0;
    n = edge_cnt + 1;
    push(0, n,      4'b0000, 0, 1, 0, "hold_exit");
    push(0, n + 15, 4'b0000, 0, 1, 0, "pre_s0");
    push(0, n + 16, 4'b0001, 0, 1, 0, "s0");
    push(0, n + 19, 4'b0001, 0, 1, 0, "seq_mid");
    drain();
    req_a = 1'b1;
    push(0, n + 20, 4'b0001, 0, 1, 0, "ign_req");
    drain();
    req_a = 1'b0;
    push(0, n + 21, 4'b0001, 0, 1, 0, "ign_noack");
    push(0, n + 31, 4'b0001, 0, 1, 0, "pre_s1");
    push(0, n + 32, 4'b0011, 0, 1, 0, "s1");
    push(0, n + 47, 4'b0011, 0, 1, 0, "pre_s2");
    push(0, n + 48, 4'b0111, 0, 1, 0, "s2");
    push(0, n + 63, 4'b0111, 0, 1, 0, "pre_s3");
    push(0, n + 64, 4'b1111, 0, 1, 0, "s3");
    push(0, n + 65, 4'b1111, 1, 0, 0, "done");
    push(0, n + 69, 4'b1111, 1, 0, 0, "done_idle");
    drain();

    // Soft reset from DONE: ack, 32-cycle hold, full replay
    req_a = 1'b1;
    e = n + 70;
    push(0, e, 4'b0000, 0, 1, 1, "soft_ack");
    drain();
    req_a = 1'b0;
    x = e + 32;
    push(0, e + 1,  4'b0000, 0, 1, 0, "ack_once");
    push(0, e + 31, 4'b0000, 0, 1, 0, "soft_hold");
    push(0, x,      4'b0000, 0, 1, 0, "soft_exit");
    push(0, x + 15, 4'b0000, 0, 1, 0, "re_pre_s0");
    push(0, x + 16, 4'b0001, 0, 1, 0, "re_s0");
    push(0, x + 48, 4'b0111, 0, 1, 0, "re_s2");
    push(0, x + 64, 4'b1111, 0, 1, 0, "re_s3");
    push(0, x + 65, 4'b1111, 1, 0, 0, "re_done");
    drain();

    // Reset from DONE takes effect without a clock edge
    rst_a = 1'b1;
    #1;
    cmp("async_done_rst", obs(0), 7'b0000_010);
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    n = edge_cnt + 1;
    push(0, n + 9, 4'b0000, 0, 1, 0, "c_pre_req");
    drain();
    req_a = 1'b1;
    push(0, n + 16, 4'b0001, 0, 1, 0, "c_s0");
    push(0, n + 40, 4'b0011, 0, 1, 0, "c_s1");
    drain();

    // Mid-sequence reset with stages 0,1 released, request level kept high
    rst_a = 1'b1;
    #1;
    cmp("async_mid_rst", obs(0), 7'b0000_010);
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    n = edge_cnt + 1;
    push(0, n,      4'b0000, 0, 1, 0, "d_hold_exit");
    push(0, n + 15, 4'b0000, 0, 1, 0, "d_pre_s0");
    push(0, n + 16, 4'b0001, 0, 1, 0, "d_s0");
    push(0, n + 64, 4'b1111, 0, 1, 0, "d_s3");
    push(0, n + 65, 4'b1111, 1, 0, 0, "d_done");
    push(0, n + 66, 4'b1111, 1, 0, 0, "held_noack");
    push(0, n + 70, 4'b1111, 1, 0, 0, "held_noack2");
    drain();
    req_a = 1'b0;
    push(0, n + 72, 4'b1111, 1, 0, 0, "req_low");
    drain();
    req_a = 1'b1;
    push(0, n + 73, 4'b0000, 0, 1, 1, "reraise_ack");
    push(0, n + 74, 4'b0000, 0, 1, 0, "one_ack");
    push(0, n + 75, 4'b0000, 0, 1, 0, "one_ack2");
    drain();
    req_a = 1'b0;

    // Corner instance: one stage, one-cycle gap and hold
    rst_b = 1'b0;
    n = edge_cnt + 1;
    push(1, n,     4'b0000, 0, 1, 0, "b_hold_exit");
    push(1, n + 1, 4'b0001, 0, 1, 0, "b_s0");
    push(1, n + 2, 4'b0001, 1, 0, 0, "b_done");
    push(1, n + 4, 4'b0001, 1, 0, 0, "b_idle");
    drain();
    req_b = 1'b1;
    e = n + 5;
    push(1, e, 4'b0000, 0, 1, 1, "b_ack");
    drain();
    req_b = 1'b0;
    push(1, e + 1, 4'b0000, 0, 1, 0, "b_soft_exit");
    push(1, e + 2, 4'b0001, 0, 1, 0, "b_re_s0");
    push(1, e + 3, 4'b0001, 1, 0, 0, "b_re_done");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
